// File: rtl/jtriders_pkg.sv
// Shared types and defaults for the riders core object-DMA logic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jtriders_pkg;

   localparam int OBJDMA_AW   = 10;   // object table word-address width
   localparam int OBJDMA_TOUT = 255;  // cpu_cen ticks allowed for a bus grant

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      OWN,
      COPY,
      REL
   } objdma_st_t;

endpackage

// File: rtl/jtriders_objdma.sv
// Object-RAM DMA master: per frame, takes the 68k bus and copies the object table to the shadow buffer.
// Latency: request on the clk after the LVBL fall; copy takes 2**AW+1 clks once the bus is owned.
// Backpressure: waits for BGn on cpu_cen ticks, gives up after TOUT ticks; the copy itself never stalls.
//
// Ports:
//   clk, rstn            system clock, synchronous active-low reset
//   cpu_cen              68k clock enable; bus handshake only advances on it
//   LVBL, dma_en         vertical blank (active low) and DMA enable from the object register
//   ASn, BGn             68k address strobe and bus grant
//   BRn, BGACKn          bus request / grant acknowledge to the 68k (active low)
//   busy, tout           status bits: transfer in progress, last request timed out (sticky)
//   src_addr, src_dout   object RAM read port (1-clk synchronous read)
//   dst_addr, dst_din,   shadow buffer write port, one dst_we pulse per word
//   dst_we
module jtriders_objdma
   import jtriders_pkg::*;
#(
   parameter int AW   = OBJDMA_AW,
   parameter int TOUT = OBJDMA_TOUT
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          cpu_cen,
   input  logic          LVBL,
   input  logic          dma_en,
   input  logic          ASn,
   input  logic          BGn,
   output logic          BRn,
   output logic          BGACKn,
   output logic          busy,
   output logic          tout,
   output logic [AW-1:0] src_addr,
   input  logic [15:0]   src_dout,
   output logic [AW-1:0] dst_addr,
   output logic [15:0]   dst_din,
   output logic          dst_we
);

   localparam int CW = $clog2(TOUT + 1);

   objdma_st_t    st;
   logic          lvbl_l;
   logic [CW-1:0] cnt;
   logic [AW-1:0] addr_d;    // address whose data arrives on src_dout this clk
   logic          rd_pend;   // a read was issued on the previous clk
   logic          done;      // last address issued; avoids relying on counter wrap
   logic          trig;

   // Start of vertical blank
   assign trig = lvbl_l & ~LVBL;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         st       <= IDLE;
         lvbl_l   <= 1'b0;
         cnt      <= '0;
         addr_d   <= '0;
         rd_pend  <= 1'b0;
         done     <= 1'b0;
         BRn      <= 1'b1;
         BGACKn   <= 1'b1;
         busy     <= 1'b0;
         tout     <= 1'b0;
         src_addr <= '0;
         dst_addr <= '0;
         dst_din  <= '0;
         dst_we   <= 1'b0;
      end else begin
         lvbl_l <= LVBL;
         dst_we <= 1'b0;
         case (st)
            IDLE: begin
               // Edges seen outside IDLE are simply dropped
               if (trig && dma_en) begin
                  BRn      <= 1'b0;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  src_addr <= '0;
                  done     <= 1'b0;
                  rd_pend  <= 1'b0;
                  st       <= REQ;
               end
            end
            REQ: begin
               if (cpu_cen) begin
                  // Only take the bus once the current CPU cycle has ended
                  if (!BGn && ASn) begin
                     BGACKn <= 1'b0;
                     st     <= OWN;
                  end else if (cnt == CW'(TOUT - 1)) begin
                     BRn  <= 1'b1;
                     busy <= 1'b0;
                     tout <= 1'b1;
                     st   <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            OWN: begin
               // BGACKn now holds the bus, so the request can be withdrawn
               if (cpu_cen) begin
                  BRn <= 1'b1;
                  st  <= COPY;
               end
            end
            COPY: begin
               // Issue side: one read address per clk until the last one
               if (!done) begin
                  addr_d  <= src_addr;
                  rd_pend <= 1'b1;
                  if (src_addr == {AW{1'b1}}) begin
                     done <= 1'b1;
                  end else begin
                     src_addr <= src_addr + 1'b1;
                  end
               end else begin
                  rd_pend <= 1'b0;
               end
               // Write side: data for the previous clk's address is on src_dout
               if (rd_pend) begin
                  dst_we   <= 1'b1;
                  dst_addr <= addr_d;
                  dst_din  <= src_dout;
               end
               // The final write happens on this same clk
               if (done) begin
                  st <= REL;
               end
            end
            REL: begin
               if (cpu_cen) begin
                  BGACKn <= 1'b1;
                  busy   <= 1'b0;
                  tout   <= 1'b0;
                  st     <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtriders_objdma.sv
// Self-checking bench for jtriders_objdma: random cpu_cen, a 68k grant model and a shadow-buffer scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_jtriders_objdma;

   localparam int AW    = 10;
   localparam int WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          rstn, cpu_cen, LVBL, dma_en, ASn, BGn;
   logic          BRn, BGACKn, busy, tout, dst_we;
   logic [AW-1:0] src_addr, dst_addr;
   logic [15:0]   src_dout, dst_din;

   jtriders_objdma u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .cpu_cen  (cpu_cen),
      .LVBL     (LVBL),
      .dma_en   (dma_en),
      .ASn      (ASn),
      .BGn      (BGn),
      .BRn      (BRn),
      .BGACKn   (BGACKn),
      .busy     (busy),
      .tout     (tout),
      .src_addr (src_addr),
      .src_dout (src_dout),
      .dst_addr (dst_addr),
      .dst_din  (dst_din),
      .dst_we   (dst_we)
   );

   always #5 clk = ~clk;

   // Object RAM model with a 1-clk synchronous read
   logic [15:0] mem [WORDS];
   always @(posedge clk) src_dout <= mem[src_addr];

   int  errs   = 0;
   int  checks = 0;

   // Environment knobs owned by the main process
   bit  grant   = 1'b1;   // 68k grants: BGn follows BRn two cen ticks late
   bit  cen_off = 1'b0;   // hold cpu_cen low

   // Scoreboard, updated by the environment process
   int  cen_cnt   = 0;
   int  wcount    = 0;
   int  dup_err   = 0;
   int  data_err  = 0;
   int  order_err = 0;
   int  first_addr = -1;
   bit  wr_hit [WORDS];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_sb();
      wcount = 0; dup_err = 0; data_err = 0; order_err = 0; first_addr = -1;
      for (int i = 0; i < WORDS; i++) wr_hit[i] = 1'b0;
   endtask

   // Environment: cen generation, 68k grant model, shadow-buffer capture.
   // Runs 2 time units after each rising edge, well clear of both clock edges.
   initial begin
      logic br_d1, br_d2;
      br_d1 = 1'b1; br_d2 = 1'b1;
      cpu_cen = 1'b0;
      BGn = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (cpu_cen) begin
            cen_cnt++;
            br_d2 = br_d1;
            br_d1 = BRn;
         end
         if (!rstn) begin
            br_d1 = 1'b1; br_d2 = 1'b1;
         end
         BGn = grant ? br_d2 : 1'b1;
         if (dst_we) begin
            if (first_addr < 0) first_addr = int'(dst_addr);
            if (wr_hit[dst_addr]) dup_err++;
            wr_hit[dst_addr] = 1'b1;
            if (dst_din !== mem[dst_addr]) data_err++;
            if (int'(dst_addr) != wcount) order_err++;
            wcount++;
         end
         cpu_cen = cen_off ? 1'b0 : ($urandom_range(0, 3) == 0);
      end
   end

   task automatic trigger();
      LVBL = 1'b1;
      repeat (3) @(negedge clk);
      LVBL = 1'b0;
   endtask

   // Full granted transfer with end-to-end checks.
   // drop_en: lower dma_en once requested; inject: second LVBL fall mid-copy.
   task automatic dma_cycle(input string tag, input bit drop_en, input bit inject);
      int n, c0, inj_t;
      clear_sb();
      grant = 1'b1;
      trigger();
      n = 0;
      while (BRn && n < 50) begin @(negedge clk); n++; end
      chk({tag, ".req"}, BRn, 1'b0);
      chk({tag, ".busy"}, busy, 1'b1);
      if (drop_en) dma_en = 1'b0;
      n = 0;
      while (BGACKn && n < 5000) begin @(negedge clk); n++; end
      chk({tag, ".ack"}, BGACKn, 1'b0);
      c0 = cen_cnt;
      n = 0;
      while (!BRn && n < 5000) begin @(negedge clk); n++; end
      chk({tag, ".br_rel_cens"}, cen_cnt - c0, 1);
      n = 0; inj_t = 0;
      while (busy && n < 20000) begin
         @(negedge clk); n++;
         if (inject && wcount >= 500 && inj_t < 4) begin
            inj_t++;
            LVBL = (inj_t < 4);
         end
      end
      chk({tag, ".idle"}, busy, 1'b0);
      chk({tag, ".writes"}, wcount, WORDS);
      chk({tag, ".first"}, first_addr, 0);
      chk({tag, ".dup"}, dup_err, 0);
      chk({tag, ".data"}, data_err, 0);
      chk({tag, ".order"}, order_err, 0);
      chk({tag, ".bgack"}, BGACKn, 1'b1);
      chk({tag, ".tout"}, tout, 1'b0);
      dma_en = 1'b1;
   endtask

   initial begin
      int n, c0, low_seen, wc;
      rstn = 1'b0; LVBL = 1'b1; dma_en = 1'b1; ASn = 1'b1;
      for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom);
      clear_sb();
      repeat (4) @(negedge clk);

      // Reset state
      chk("rst.BRn", BRn, 1'b1);
      chk("rst.BGACKn", BGACKn, 1'b1);
      chk("rst.busy", busy, 1'b0);
      chk("rst.tout", tout, 1'b0);
      chk("rst.dst_we", dst_we, 1'b0);
      chk("rst.src_addr", src_addr, 0);
      chk("rst.dst_addr", dst_addr, 0);
      chk("rst.dst_din", dst_din, 0);
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      // Normal transfer; dma_en dropping mid-transfer must not abort it
      dma_cycle("t1", 1'b1, 1'b0);

      // Disabled: LVBL fall ignored
      dma_en = 1'b0; clear_sb();
      trigger();
      low_seen = 0;
      repeat (300) begin @(negedge clk); if (!BRn) low_seen++; end
      chk("t2.no_req", low_seen, 0);
      chk("t2.no_write", wcount, 0);
      chk("t2.busy", busy, 1'b0);
      dma_en = 1'b1;

      // Address strobe held low while granted delays the acknowledge
      clear_sb(); grant = 1'b1; ASn = 1'b0;
      trigger();
      n = 0;
      while (BGn && n < 5000) begin @(negedge clk); n++; end
      chk("t4.bg", BGn, 1'b0);
      c0 = cen_cnt; low_seen = 0; n = 0;
      while (cen_cnt - c0 < 5 && n < 5000) begin
         @(negedge clk); n++;
         if (!BGACKn) low_seen++;
      end
      chk("t4.no_ack_asn", low_seen, 0);
      ASn = 1'b1;
      c0 = cen_cnt; n = 0;
      while (BGACKn && n < 5000) begin @(negedge clk); n++; end
      chk("t4.ack_cens", cen_cnt - c0, 1);
      n = 0;
      while (busy && n < 20000) begin @(negedge clk); n++; end
      chk("t4.writes", wcount, WORDS);

      // No grant: frozen while cen is held low, then times out after TOUT ticks
      grant = 1'b0; cen_off = 1'b1;
      trigger();
      n = 0;
      while (BRn && n < 50) begin @(negedge clk); n++; end
      repeat (400) @(negedge clk);
      chk("t3.frozen_req", BRn, 1'b0);
      chk("t3.frozen_busy", busy, 1'b1);
      chk("t3.frozen_tout", tout, 1'b0);
      c0 = cen_cnt;
      cen_off = 1'b0;
      n = 0;
      while (!BRn && n < 20000) begin @(negedge clk); n++; end
      chk("t3.tout_cens", cen_cnt - c0, 255);
      chk("t3.busy", busy, 1'b0);
      chk("t3.tout", tout, 1'b1);
      chk("t3.bgack", BGACKn, 1'b1);
      // Following successful frame clears the sticky flag
      dma_cycle("t3b", 1'b0, 1'b0);

      // Reset in the middle of the copy
      clear_sb(); grant = 1'b1;
      trigger();
      n = 0;
      while (wcount < 300 && n < 20000) begin @(negedge clk); n++; end
      rstn = 1'b0;
      @(negedge clk);
      chk("t5.BRn", BRn, 1'b1);
      chk("t5.BGACKn", BGACKn, 1'b1);
      chk("t5.dst_we", dst_we, 1'b0);
      chk("t5.busy", busy, 1'b0);
      wc = wcount;
      repeat (5) @(negedge clk);
      chk("t5.stopped", wcount, wc);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      dma_cycle("t5b", 1'b0, 1'b0);

      // Second LVBL fall during copy is dropped
      dma_cycle("t6", 1'b0, 1'b1);
      low_seen = 0;
      repeat (300) begin @(negedge clk); if (!BRn) low_seen++; end
      chk("t6.no_rereq", low_seen, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
